dmem_led_probe: RTL and testbench

Debug read-out block for the pipelined MIPS top. It samples a switch-selected data-memory address and reads the word through a dedicated req/ack debug port. It then scans the word onto the board LEDs one LED_W-bit segment at a time. This is the parametrised successor of the fixed 6-bit-address / 8-LED memory display path: generic widths, handshaked memory access, periodic refresh, and a hold (Hack) mode.

---
 rtl/dmem_led_probe_pkg.sv | 17 +
 rtl/dmem_led_probe_tick_counter.sv | 31 +++
 rtl/dmem_led_probe.sv | 154 +++++++++++++++
 tb/tb_dmem_led_probe.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_led_probe_pkg.sv
// Shared FSM state type, fill pattern and segment sizing helpers for dmem_led_probe.
package dmem_probe_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, SHOW} probe_state_e;

  // Shown on every LED segment when a read times out: alternating on/off pairs.
  localparam logic [1:0] FILL_PAIR = 2'b10;

  function automatic int unsigned seg_n(input int unsigned data_w, input int unsigned led_w);
    return data_w / led_w;
  endfunction

  function automatic int unsigned seg_w(input int unsigned data_w, input int unsigned led_w);
    return (data_w / led_w > 1) ? $clog2(data_w / led_w) : 1;
  endfunction

endpackage

// File: rtl/dmem_led_probe_tick_counter.sv
// Wrap counter 0..MAX-1 with enable, hold and clear; tc pulses on the wrapping cycle.
module probe_tick_counter #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic hold,
  input  logic clr,
  output logic tc
);

  localparam int unsigned CW = (MAX > 1) ? $clog2(MAX) : 1;

  logic [CW-1:0] count;
  logic          at_top;

  assign at_top = (count == CW'(MAX - 1));
  assign tc     = en && !hold && !clr && at_top;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !hold) begin
      count <= at_top ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_led_probe.sv
// Debug probe: reads a switch-selected data-memory word over req/ack and scans it onto the LEDs.
// Optional ack timeout (fill pattern + timeout_flag port): define PROBE_TIMEOUT_EN.
module dmem_led_probe
  import dmem_probe_pkg::*;
#(
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned LED_W          = 8,
  parameter int unsigned SCAN_CYCLES    = 25000000,
  parameter int unsigned REFRESH_CYCLES = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 hack,
  input  logic [ADDR_W-1:0]                    probe_addr,
  output logic                                 mem_rd_req,
  output logic [ADDR_W-1:0]                    mem_rd_addr,
  input  logic                                 mem_rd_ack,
  input  logic [DATA_W-1:0]                    mem_rd_data,
  output logic [LED_W-1:0]                     led,
  output logic [seg_w(DATA_W, LED_W)-1:0]      seg_idx,
  output logic                                 busy
`ifdef PROBE_TIMEOUT_EN
  ,
  output logic                                 timeout_flag
`endif
);

  localparam int unsigned SEG_N = seg_n(DATA_W, LED_W);
  localparam int unsigned SEG_W = seg_w(DATA_W, LED_W);
  localparam logic [DATA_W-1:0] FILL_WORD = {(DATA_W/2){FILL_PAIR}};

  if ((DATA_W % LED_W) != 0 || (LED_W % 2) != 0 || SCAN_CYCLES < 1 ||
      REFRESH_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("dmem_led_probe: unsupported parameter combination");
  end

  probe_state_e      state, state_nxt;
  logic [DATA_W-1:0] word, word_nxt;
  logic [SEG_W-1:0]  seg_nxt;
  logic [ADDR_W-1:0] last_addr;
  logic              refreshing;
  logic              reading, in_show, ack_ok, addr_chg;
  logic              scan_tc, refresh_tc, timeout_hit;

  assign reading    = (state == REQ) || (state == WAIT);
  assign in_show    = (state == SHOW);
  assign ack_ok     = reading && mem_rd_ack;
  assign addr_chg   = in_show && !hack && (probe_addr != last_addr);
  assign mem_rd_req = reading;
  assign busy       = reading;

  // A refresh read keeps the scan running so the new word replaces the old in place.
  probe_tick_counter #(.MAX(SCAN_CYCLES)) u_scan (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (in_show || (reading && refreshing)),
    .hold (hack),
    .clr  (addr_chg || (ack_ok && !refreshing)),
    .tc   (scan_tc)
  );

  probe_tick_counter #(.MAX(REFRESH_CYCLES)) u_refresh (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (in_show),
    .hold (hack),
    .clr  (addr_chg),
    .tc   (refresh_tc)
  );

`ifdef PROBE_TIMEOUT_EN
  logic timeout_tc;

  probe_tick_counter #(.MAX(TIMEOUT_CYCLES)) u_timeout (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (reading),
    .hold (1'b0),
    .clr  (!reading || mem_rd_ack),
    .tc   (timeout_tc)
  );

  assign timeout_hit = timeout_tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_flag <= 1'b0;
    end else if (ack_ok) begin
      timeout_flag <= 1'b0;
    end else if (timeout_hit) begin
      timeout_flag <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    word_nxt  = word;
    seg_nxt   = seg_idx;
    unique case (state)
      IDLE: state_nxt = REQ;
      REQ, WAIT: begin
        if (mem_rd_ack) begin
          state_nxt = SHOW;
          word_nxt  = mem_rd_data;
        end else if (timeout_hit) begin
          state_nxt = SHOW;
          word_nxt  = FILL_WORD;
        end else begin
          state_nxt = WAIT;
        end
      end
      SHOW: if (addr_chg || refresh_tc) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
    if (addr_chg || (ack_ok && !refreshing)) begin
      seg_nxt = '0;
    end else if (scan_tc) begin
      seg_nxt = (seg_idx == SEG_W'(SEG_N - 1)) ? '0 : seg_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      word        <= '0;
      seg_idx     <= '0;
      led         <= '0;
      mem_rd_addr <= '0;
      last_addr   <= '0;
      refreshing  <= 1'b0;
    end else begin
      state   <= state_nxt;
      word    <= word_nxt;
      seg_idx <= seg_nxt;
      // Driven from next-state values so led tracks word/seg_idx on the same edge.
      led     <= word_nxt[seg_nxt*LED_W +: LED_W];
      if (state == IDLE || addr_chg) begin
        mem_rd_addr <= probe_addr;
        last_addr   <= probe_addr;
      end
      if (addr_chg) begin
        refreshing <= 1'b0;
      end else if (refresh_tc) begin
        refreshing <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_led_probe.sv
// Self-checking bench for dmem_led_probe: cycle-level reference model, directed scenarios, random phase.
`timescale 1ns/1ps
module tb_dmem_led_probe;

  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 32;
  localparam int LED_W   = 8;
  localparam int SCAN    = 4;
  localparam int REFRESH = 32;
  localparam int TIMEOUT = 8;
  localparam int SEGS    = DATA_W / LED_W;
`ifdef PROBE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              hack;
  logic [ADDR_W-1:0] probe_addr;
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_ack;
  logic [DATA_W-1:0] mem_rd_data;
  logic [LED_W-1:0]  led;
  logic [1:0]        seg_idx;
  logic              busy;
`ifdef PROBE_TIMEOUT_EN
  logic              timeout_flag;
`endif

  always #5 clk = ~clk;

  dmem_led_probe #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .LED_W         (LED_W),
    .SCAN_CYCLES   (SCAN),
    .REFRESH_CYCLES(REFRESH),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hack        (hack),
    .probe_addr  (probe_addr),
    .mem_rd_req  (mem_rd_req),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_ack  (mem_rd_ack),
    .mem_rd_data (mem_rd_data),
    .led         (led),
    .seg_idx     (seg_idx),
    .busy        (busy)
`ifdef PROBE_TIMEOUT_EN
    ,
    .timeout_flag(timeout_flag)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=0x%0h want=0x%0h at %0t", name, got, want, $time);
  endtask

  // ---------------- reference model ----------------
  bit                m_boot = 0, m_pend = 0, m_refr_rd = 0, m_tflag = 0;
  int                m_age = 0, m_scan = 0, m_seg = 0, m_refc = 0;
  logic [ADDR_W-1:0] m_addr = '0, m_last = '0;
  logic [DATA_W-1:0] m_word = '0;

  task automatic model_reset();
    m_boot = 0; m_pend = 0; m_refr_rd = 0; m_tflag = 0;
    m_age = 0; m_scan = 0; m_seg = 0; m_refc = 0;
    m_addr = '0; m_last = '0; m_word = '0;
  endtask

  task automatic scan_step();
    if (m_scan == SCAN - 1) begin
      m_scan = 0;
      m_seg  = (m_seg + 1) % SEGS;
    end else m_scan++;
  endtask

  task automatic start_read(input bit refresh);
    m_pend = 1; m_refr_rd = refresh; m_age = 0;
  endtask

  task automatic model_step();
    if (!m_boot) begin
      m_boot = 1;
      m_addr = probe_addr; m_last = probe_addr;
      start_read(0);
    end else if (m_pend) begin
      if (m_refr_rd && !hack) scan_step();
      if (mem_rd_ack) begin
        m_word = mem_rd_data; m_pend = 0; m_tflag = 0;
        if (!m_refr_rd) begin m_seg = 0; m_scan = 0; end
      end else if (TO_EN && m_age == TIMEOUT - 1) begin
        m_word = 32'hAAAA_AAAA; m_pend = 0; m_tflag = 1;
      end else m_age++;
    end else if (!hack) begin
      if (probe_addr != m_last) begin
        m_addr = probe_addr; m_last = probe_addr;
        m_scan = 0; m_seg = 0; m_refc = 0;
        start_read(0);
      end else begin
        scan_step();
        if (m_refc == REFRESH - 1) begin
          m_refc = 0;
          start_read(1);
        end else m_refc++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clk);
    check("req",  64'(mem_rd_req),  64'(m_pend));
    check("busy", 64'(busy),        64'(m_pend));
    check("addr", 64'(mem_rd_addr), 64'(m_addr));
    check("seg",  64'(seg_idx),     64'(m_seg));
    check("led",  64'(led),         64'(m_word[m_seg*LED_W +: LED_W]));
`ifdef PROBE_TIMEOUT_EN
    check("tflag", 64'(timeout_flag), 64'(m_tflag));
`endif
  end

  // ---------------- memory side ----------------
  logic [DATA_W-1:0] mem [64];
  bit ack_en = 1, rand_lat = 0, spur_en = 0, mut_en = 0;
  int fixed_lat = 3;
  int req_age = 0, lat = 3;

  initial begin
    mem_rd_ack  = 1'b0;
    mem_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mut_en && $urandom_range(0, 63) == 0) mem[$urandom_range(0, 63)] = $urandom;
      if (!rst_n) begin
        mem_rd_ack = 1'b0; req_age = 0;
      end else if (mem_rd_req && ack_en) begin
        mem_rd_ack = (req_age == lat);
        if (req_age == lat) mem_rd_data = mem[mem_rd_addr];
        req_age++;
      end else begin
        req_age = 0;
        lat = rand_lat ? int'($urandom_range(0, 4)) : fixed_lat;
        mem_rd_ack = 1'b0;
        if (spur_en && !mem_rd_req && $urandom_range(0, 15) == 0) begin
          mem_rd_ack = 1'b1; mem_rd_data = $urandom;
        end
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic wait_sig(input string name, input bit on_ack, input int limit);
    int n = 0;
    while (!(on_ack ? mem_rd_ack : mem_rd_req) && n < limit) begin
      @(negedge clk); n++;
    end
    check(name, 64'(on_ack ? mem_rd_ack : mem_rd_req), 64'(1));
  endtask

  logic [7:0]  t1_exp [5] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h44};
  logic [31:0] w;
  logic [7:0]  held_led;
  int          held_seg, n;

  initial begin
    rst_n = 1'b0; hack = 1'b0; probe_addr = 6'd5;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[5] = 32'h1122_3344;
    mem[9] = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    check("rst_led",  64'(led),         64'(0));
    check("rst_seg",  64'(seg_idx),     64'(0));
    check("rst_req",  64'(mem_rd_req),  64'(0));
    check("rst_busy", 64'(busy),        64'(0));
    check("rst_addr", 64'(mem_rd_addr), 64'(0));

    // 1: first read of address 5 and a full scan
    rst_n = 1'b1;
    wait_sig("t1_req", 0, 5);
    check("t1_addr", 64'(mem_rd_addr), 64'(5));
    wait_sig("t1_ack", 1, 10);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) repeat (SCAN) @(negedge clk);
      check("t1_led", 64'(led), 64'(t1_exp[i]));
      check("t1_seg", 64'(seg_idx), 64'(i % SEGS));
    end

    // 2: address change mid-scan
    probe_addr = 6'd9;
    @(negedge clk);
    check("t2_req",  64'(mem_rd_req),  64'(1));
    check("t2_addr", 64'(mem_rd_addr), 64'(9));
    wait_sig("t2_ack", 1, 10);
    @(negedge clk);
    check("t2_led", 64'(led), 64'(8'hEF));
    check("t2_seg", 64'(seg_idx), 64'(0));

    // 3: memory content changes, refresh picks it up in place
    probe_addr = 6'd5;
    @(negedge clk);
    wait_sig("t3_ack0", 1, 10);
    @(negedge clk);
    mem[5] = 32'hAABB_CCDD;
    wait_sig("t3_refresh", 1, REFRESH + 12);
    check("t3_addr", 64'(mem_rd_addr), 64'(5));
    @(negedge clk);
    w = 32'hAABB_CCDD;
    check("t3_led", 64'(led), 64'(w[m_seg*LED_W +: LED_W]));

    // 4: hack freezes the display and blocks reads
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    held_led = m_word[m_seg*LED_W +: LED_W];
    held_seg = m_seg;
    hack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t4_led", 64'(led), 64'(held_led));
      check("t4_seg", 64'(seg_idx), 64'(held_seg));
      check("t4_noreq", 64'(mem_rd_req), 64'(0));
    end
    hack = 1'b0;
    n = 0;
    while (seg_idx == 2'(held_seg) && n < SCAN + 2) begin @(negedge clk); n++; end
    check("t4_resume", 64'(seg_idx), 64'((held_seg + 1) % SEGS));

    // 5: asynchronous reset during WAIT
    fixed_lat = 6;
    probe_addr = 6'd12;
    wait_sig("t5_req", 0, 4);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_req",  64'(mem_rd_req), 64'(0));
    check("t5_busy", 64'(busy),       64'(0));
    check("t5_led",  64'(led),        64'(0));
    check("t5_seg",  64'(seg_idx),    64'(0));
    fixed_lat = 3;
    @(negedge clk);
    rst_n = 1'b1;
    wait_sig("t5_rereq", 0, 5);
    check("t5_addr", 64'(mem_rd_addr), 64'(12));
    wait_sig("t5_ack", 1, 10);
    @(negedge clk);

`ifdef PROBE_TIMEOUT_EN
    // 6: no ack -> fill pattern and flag, cleared by the next successful refresh
    ack_en = 0;
    probe_addr = 6'd20;
    wait_sig("t6_req", 0, 4);
    n = 0;
    while (mem_rd_req && n < 20) begin n++; @(negedge clk); end
    check("t6_len",   64'(n),            64'(TIMEOUT));
    check("t6_led",   64'(led),          64'(8'hAA));
    check("t6_tflag", 64'(timeout_flag), 64'(1));
    ack_en = 1;
    wait_sig("t6_ack", 1, REFRESH + 12);
    @(negedge clk);
    w = mem[20];
    check("t6_tclr", 64'(timeout_flag), 64'(0));
    check("t6_data", 64'(led), 64'(w[m_seg*LED_W +: LED_W]));
`endif

    // random phase: address changes, hack toggles, variable latency, spurious acks, memory churn
    rand_lat = 1; spur_en = 1; mut_en = 1;
    repeat (2000) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) probe_addr = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 24) == 0) hack = ~hack;
    end
    hack = 1'b0; spur_en = 0; mut_en = 0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish, checks %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
